// File: rtl/cdic.sv
// CDIC host-bus block: 64 KB window with buffer RAM, a command/status register file
// and a fixed-latency command engine driven through DBUF/XBUF.
// Optional build macro: CDIC_BUFFER_RAM_EN (when defined, 7680 x 16 buffer RAM at 0x0000-0x3BFF).
module cdic (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:1] address,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic        uds,
    input  logic        lds,
    input  logic        write_strobe,
    input  logic        cs,
    output logic        bus_ack
);

    // Word offsets inside the window (byte offset >> 1)
    localparam logic [14:0] W_CMD    = 15'h1E00;
    localparam logic [14:0] W_TIME_H = 15'h1E01;
    localparam logic [14:0] W_TIME_L = 15'h1E02;
    localparam logic [14:0] W_FILE   = 15'h1E03;
    localparam logic [14:0] W_CHAN_H = 15'h1E04;
    localparam logic [14:0] W_CHAN_L = 15'h1E05;
    localparam logic [14:0] W_ACHAN  = 15'h1E06;
    localparam logic [14:0] W_ABUF   = 15'h1FFA;
    localparam logic [14:0] W_XBUF   = 15'h1FFB;
    localparam logic [14:0] W_DMACTL = 15'h1FFC;
    localparam logic [14:0] W_ZBUF   = 15'h1FFD;
    localparam logic [14:0] W_IVEC   = 15'h1FFE;
    localparam logic [14:0] W_DBUF   = 15'h1FFF;
    localparam logic [14:0] W_RAM_END = 15'h1E00;   // first word past the buffer RAM
    localparam logic [4:0]  CMD_CYCLES = 5'd16;

    // Byte-lane merge of CPU write data into an existing word
    function automatic logic [15:0] lane_merge(input logic [15:0] old_val,
                                               input logic [15:0] wdata,
                                               input logic        up,
                                               input logic        lo);
        logic [15:0] r;
        r = old_val;
        if (up) r[15:8] = wdata[15:8];
        if (lo) r[7:0]  = wdata[7:0];
        return r;
    endfunction

    logic [14:0] word_addr;
    logic        req, xfer, wr_en, rd_en;
    logic        start, done;
    logic        in_ram;
    logic [15:0] ram_rdata;
    logic [15:0] rdata;
    logic        unused_addr_bits;

    logic        bus_ack_q, bus_ack_d;
    logic [15:0] dout_q, dout_d;
    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] cmd_q, cmd_d, time_h_q, time_h_d, time_l_q, time_l_d;
    logic [15:0] file_q, file_d, chan_h_q, chan_h_d, chan_l_q, chan_l_d;
    logic [15:0] achan_q, achan_d, abuf_q, abuf_d, xbuf_q, xbuf_d;
    logic [15:0] dmactl_q, dmactl_d, zbuf_q, zbuf_d, ivec_q, ivec_d;
    logic [14:0] dbuf_q, dbuf_d;
    logic [15:0] dbuf_wr;

    assign word_addr        = address[15:1];
    assign unused_addr_bits = ^address[23:16];
    assign req              = cs & (uds | lds);
    assign xfer             = req & ~bus_ack_q;
    assign wr_en            = xfer & write_strobe;
    assign rd_en            = xfer & ~write_strobe;
    assign in_ram           = (word_addr < W_RAM_END);
    assign start            = wr_en & (word_addr == W_DBUF) & uds & din[15];
    assign done             = busy_q & (cnt_q == CMD_CYCLES) & ~start;
    assign dbuf_wr          = lane_merge({busy_q, dbuf_q}, din, uds, lds);
    assign bus_ack          = bus_ack_q;
    assign dout             = dout_q;

`ifdef CDIC_BUFFER_RAM_EN
    logic [15:0] ram [0:7679];

    // Buffer RAM: byte-lane writes, no reset so contents survive it
    always_ff @(posedge clk) begin
        if (wr_en && in_ram) begin
            if (uds) ram[word_addr[12:0]][15:8] <= din[15:8];
            if (lds) ram[word_addr[12:0]][7:0]  <= din[7:0];
        end
    end

    assign ram_rdata = in_ram ? ram[word_addr[12:0]] : 16'h0000;
`else
    assign ram_rdata = 16'h0000;
`endif

    // Read-data mux; XBUF[15] reads 0 when completion lands on the same edge
    always_comb begin
        rdata = 16'h0000;
        if (in_ram) begin
            rdata = ram_rdata;
        end else begin
            case (word_addr)
                W_CMD:    rdata = cmd_q;
                W_TIME_H: rdata = time_h_q;
                W_TIME_L: rdata = time_l_q;
                W_FILE:   rdata = file_q;
                W_CHAN_H: rdata = chan_h_q;
                W_CHAN_L: rdata = chan_l_q;
                W_ACHAN:  rdata = achan_q;
                W_ABUF:   rdata = abuf_q;
                W_XBUF:   rdata = {xbuf_q[15] & ~done, xbuf_q[14:0]};
                W_DMACTL: rdata = dmactl_q;
                W_ZBUF:   rdata = zbuf_q;
                W_IVEC:   rdata = ivec_q;
                W_DBUF:   rdata = {busy_q, dbuf_q};
                default:  rdata = 16'h0000;
            endcase
        end
    end

    // Next state: bus handshake, register writes, command engine, XBUF status
    always_comb begin
        bus_ack_d = req & ~bus_ack_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        time_h_d  = time_h_q;
        time_l_d  = time_l_q;
        file_d    = file_q;
        chan_h_d  = chan_h_q;
        chan_l_d  = chan_l_q;
        achan_d   = achan_q;
        abuf_d    = abuf_q;
        xbuf_d    = xbuf_q;
        dmactl_d  = dmactl_q;
        zbuf_d    = zbuf_q;
        ivec_d    = ivec_q;
        dbuf_d    = dbuf_q;

        if (rd_en) dout_d = rdata;

        if (wr_en) begin
            case (word_addr)
                W_CMD:    cmd_d    = lane_merge(cmd_q,    din, uds, lds);
                W_TIME_H: time_h_d = lane_merge(time_h_q, din, uds, lds);
                W_TIME_L: time_l_d = lane_merge(time_l_q, din, uds, lds);
                W_FILE:   file_d   = lane_merge(file_q,   din, uds, lds);
                W_CHAN_H: chan_h_d = lane_merge(chan_h_q, din, uds, lds);
                W_CHAN_L: chan_l_d = lane_merge(chan_l_q, din, uds, lds);
                W_ACHAN:  achan_d  = lane_merge(achan_q,  din, uds, lds);
                W_ABUF:   abuf_d   = lane_merge(abuf_q,   din, uds, lds);
                W_XBUF:   xbuf_d   = lane_merge(xbuf_q,   din, uds, lds);
                W_DMACTL: dmactl_d = lane_merge(dmactl_q, din, uds, lds);
                W_ZBUF:   zbuf_d   = lane_merge(zbuf_q,   din, uds, lds);
                W_IVEC:   ivec_d   = lane_merge(ivec_q,   din, uds, lds);
                W_DBUF:   dbuf_d   = dbuf_wr[14:0];
                default:  ;
            endcase
        end

        // Command engine: counter holds edges elapsed since the start edge
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = 5'd1;
        end else if (busy_q) begin
            if (cnt_q == CMD_CYCLES) begin
                busy_d = 1'b0;
                cnt_d  = 5'd0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end

        // Reading XBUF acknowledges the status bit; completion takes precedence
        if (rd_en && !in_ram && word_addr == W_XBUF) xbuf_d[15] = 1'b0;
        if (done) begin
            xbuf_d[15]  = 1'b1;
            xbuf_d[7:0] = cmd_q[7:0];
        end
    end

    // State registers, all cleared by asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_ack_q <= 1'b0;
            dout_q    <= 16'h0000;
            busy_q    <= 1'b0;
            cnt_q     <= 5'd0;
            cmd_q     <= 16'h0000;
            time_h_q  <= 16'h0000;
            time_l_q  <= 16'h0000;
            file_q    <= 16'h0000;
            chan_h_q  <= 16'h0000;
            chan_l_q  <= 16'h0000;
            achan_q   <= 16'h0000;
            abuf_q    <= 16'h0000;
            xbuf_q    <= 16'h0000;
            dmactl_q  <= 16'h0000;
            zbuf_q    <= 16'h0000;
            ivec_q    <= 16'h0000;
            dbuf_q    <= 15'h0000;
        end else begin
            bus_ack_q <= bus_ack_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            time_h_q  <= time_h_d;
            time_l_q  <= time_l_d;
            file_q    <= file_d;
            chan_h_q  <= chan_h_d;
            chan_l_q  <= chan_l_d;
            achan_q   <= achan_d;
            abuf_q    <= abuf_d;
            xbuf_q    <= xbuf_d;
            dmactl_q  <= dmactl_d;
            zbuf_q    <= zbuf_d;
            ivec_q    <= ivec_d;
            dbuf_q    <= dbuf_d;
        end
    end

endmodule

// File: tb/tb_cdic.sv
// Directed table-driven bench for cdic plus hand-written command/handshake sequences.
module tb_cdic;

    logic        clk;
    logic        reset;
    logic [23:1] address;
    logic [15:0] din;
    logic [15:0] dout;
    logic        uds, lds, write_strobe, cs;
    logic        bus_ack;

    int checks = 0;
    int errors = 0;

`ifdef CDIC_BUFFER_RAM_EN
    localparam logic [15:0] RAM_EXP = 16'h5A5A;
`else
    localparam logic [15:0] RAM_EXP = 16'h0000;
`endif

    localparam logic [23:0] A_CMD  = 24'h303C00;
    localparam logic [23:0] A_FILE = 24'h303C06;
    localparam logic [23:0] A_XBUF = 24'h303FF6;
    localparam logic [23:0] A_IVEC = 24'h303FFC;
    localparam logic [23:0] A_DBUF = 24'h303FFE;
    localparam logic [23:0] A_RAM  = 24'h300100;

    cdic dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .din          (din),
        .dout         (dout),
        .uds          (uds),
        .lds          (lds),
        .write_strobe (write_strobe),
        .cs           (cs),
        .bus_ack      (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        logic [15:0] data;
        bit          u;
        bit          l;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input bit wr, input logic [23:0] a, input logic [15:0] d,
                             input bit u, input bit l);
        address      = a[23:1];
        din          = d;
        uds          = u;
        lds          = l;
        write_strobe = wr;
        cs           = 1'b1;
    endtask

    task automatic drop_req();
        cs  = 1'b0;
        uds = 1'b0;
        lds = 1'b0;
    endtask

    // One complete transfer; returns one edge after the ack edge (+1 ns)
    task automatic do_xfer(input bit wr, input logic [23:0] a, input logic [15:0] d,
                           input bit u, input bit l, output logic [15:0] rd);
        bit got;
        @(negedge clk);
        drive_req(wr, a, d, u, l);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus_ack) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_rise addr=%h actual=0 expected=1", a);
        end
        rd = dout;
        drop_req();
        @(posedge clk);
        #1;
        check("ack_one_cycle", {15'd0, bus_ack}, 16'd0);
    endtask

    // Transfer whose ack lands exactly k edges after the previous ack edge (k >= 2);
    // must be called directly after do_xfer/xfer_at returns
    task automatic xfer_at(input int k, input bit wr, input logic [23:0] a,
                           input logic [15:0] d, input bit u, input bit l,
                           output logic [15:0] rd);
        repeat (k - 2) @(posedge clk);
        #1;
        drive_req(wr, a, d, u, l);
        @(posedge clk);
        #1;
        check("ack_at_edge", {15'd0, bus_ack}, 16'd1);
        rd = dout;
        drop_req();
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[18];
    logic [15:0] rd;

    initial begin
        vecs[0]  = '{1'b1, A_CMD,        16'h1234, 1'b1, 1'b1, 16'h0000};
        vecs[1]  = '{1'b0, A_CMD,        16'h0000, 1'b1, 1'b1, 16'h1234};
        vecs[2]  = '{1'b1, A_FILE,       16'hABCD, 1'b1, 1'b1, 16'h0000};
        vecs[3]  = '{1'b1, A_FILE,       16'h0099, 1'b0, 1'b1, 16'h0000};
        vecs[4]  = '{1'b0, A_FILE,       16'h0000, 1'b1, 1'b1, 16'hAB99};
        vecs[5]  = '{1'b1, 24'h303C02,   16'h5555, 1'b1, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 24'h303C02,   16'h0000, 1'b1, 1'b1, 16'h5500};
        vecs[7]  = '{1'b1, A_IVEC,       16'hBEEF, 1'b1, 1'b1, 16'h0000};
        vecs[8]  = '{1'b0, A_IVEC,       16'h0000, 1'b1, 1'b1, 16'hBEEF};
        vecs[9]  = '{1'b1, 24'h303D00,   16'h1111, 1'b1, 1'b1, 16'h0000};
        vecs[10] = '{1'b0, 24'h303D00,   16'h0000, 1'b1, 1'b1, 16'h0000};
        vecs[11] = '{1'b1, A_RAM,        16'h5A5A, 1'b1, 1'b1, 16'h0000};
        vecs[12] = '{1'b0, A_RAM,        16'h0000, 1'b1, 1'b1, RAM_EXP};
        vecs[13] = '{1'b1, 24'h303C0C,   16'h7E81, 1'b1, 1'b1, 16'h0000};
        vecs[14] = '{1'b0, 24'h303C0C,   16'h0000, 1'b1, 1'b1, 16'h7E81};
        vecs[15] = '{1'b0, 24'h303C04,   16'h0000, 1'b1, 1'b1, 16'h0000};
        vecs[16] = '{1'b1, 24'h303FF4,   16'hC3C3, 1'b1, 1'b1, 16'h0000};
        vecs[17] = '{1'b0, 24'h303FF4,   16'h0000, 1'b0, 1'b1, 16'hC3C3};

        reset = 1'b1;
        address = '0; din = '0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0; cs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {15'd0, bus_ack}, 16'd0);
        check("reset_dout", dout, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Table: single transfers, byte lanes, unmapped and RAM windows
        foreach (vecs[i]) begin
            do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].u, vecs[i].l, rd);
            if (!vecs[i].wr) check($sformatf("vec%0d_read", i), rd, vecs[i].exp);
        end

        // Command completes on edge 16: still busy when sampled there
        do_xfer(1'b1, A_CMD, 16'h0023, 1'b1, 1'b1, rd);
        do_xfer(1'b1, A_DBUF, 16'h8000, 1'b1, 1'b1, rd);
        xfer_at(16, 1'b0, A_DBUF, 16'h0, 1'b1, 1'b1, rd);
        check("busy_at_edge16", rd, 16'h8000);
        do_xfer(1'b0, A_XBUF, 16'h0, 1'b1, 1'b1, rd);
        check("xbuf_done", rd, 16'h8023);
        do_xfer(1'b0, A_XBUF, 16'h0, 1'b1, 1'b1, rd);
        check("xbuf_cleared", rd, 16'h0023);

        // Idle by edge 17
        do_xfer(1'b1, A_DBUF, 16'h8000, 1'b1, 1'b1, rd);
        xfer_at(17, 1'b0, A_DBUF, 16'h0, 1'b1, 1'b1, rd);
        check("idle_at_edge17", rd, 16'h0000);
        do_xfer(1'b0, A_XBUF, 16'h0, 1'b1, 1'b1, rd);
        check("xbuf_done2", rd, 16'h8023);

        // Restart while busy extends the command
        do_xfer(1'b1, A_DBUF, 16'h8000, 1'b1, 1'b1, rd);
        xfer_at(8, 1'b1, A_DBUF, 16'h8000, 1'b1, 1'b1, rd);
        xfer_at(16, 1'b0, A_DBUF, 16'h0, 1'b1, 1'b1, rd);
        check("restart_busy", rd, 16'h8000);
        xfer_at(2, 1'b0, A_DBUF, 16'h0, 1'b1, 1'b1, rd);
        check("restart_idle", rd, 16'h0000);
        do_xfer(1'b0, A_XBUF, 16'h0, 1'b1, 1'b1, rd);
        check("restart_xbuf", rd, 16'h8023);

        // Completion and XBUF read on the same edge
        do_xfer(1'b1, A_CMD, 16'h0042, 1'b1, 1'b1, rd);
        do_xfer(1'b1, A_DBUF, 16'h8000, 1'b1, 1'b1, rd);
        xfer_at(16, 1'b0, A_XBUF, 16'h0, 1'b1, 1'b1, rd);
        check("collide_read", rd, 16'h0023);
        do_xfer(1'b0, A_XBUF, 16'h0, 1'b1, 1'b1, rd);
        check("collide_xbuf_set", rd, 16'h8042);
        do_xfer(1'b0, A_XBUF, 16'h0, 1'b1, 1'b1, rd);
        check("collide_xbuf_clr", rd, 16'h0042);

        // Held read request: ack alternates
        @(negedge clk);
        drive_req(1'b0, A_FILE, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("held_ack%0d", i), {15'd0, bus_ack}, (i % 2 == 1) ? 16'd1 : 16'd0);
            if (i < 5) @(negedge clk);
        end
        drop_req();
        @(negedge clk);
        check("held_dout", dout, 16'hAB99);
        check("held_ack_drop", {15'd0, bus_ack}, 16'd0);

        // Reset 5 cycles into a command aborts it
        do_xfer(1'b1, A_DBUF, 16'h8000, 1'b1, 1'b1, rd);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_dout", dout, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        do_xfer(1'b0, A_XBUF, 16'h0, 1'b1, 1'b1, rd);
        check("abort_xbuf", rd, 16'h0000);
        do_xfer(1'b0, A_DBUF, 16'h0, 1'b1, 1'b1, rd);
        check("abort_dbuf", rd, 16'h0000);
        do_xfer(1'b0, A_CMD, 16'h0, 1'b1, 1'b1, rd);
        check("abort_cmd", rd, 16'h0000);
        do_xfer(1'b0, A_FILE, 16'h0, 1'b1, 1'b1, rd);
        check("abort_file", rd, 16'h0000);
        do_xfer(1'b0, A_IVEC, 16'h0, 1'b1, 1'b1, rd);
        check("abort_ivec", rd, 16'h0000);
        do_xfer(1'b0, A_RAM, 16'h0, 1'b1, 1'b1, rd);
        check("ram_survives_reset", rd, RAM_EXP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdic.md
CDIC -- requirements
Module: cdic

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 address  input  23  CPU word address [23:1]; only [15:1] is decoded inside the 64 KB window.
REQ-004 din  input  16  CPU write data.
REQ-005 dout  output  16  registered read data.
REQ-006 uds  input  1  upper byte strobe, selects [15:8].
REQ-007 lds  input  1  lower byte strobe, selects [7:0].
REQ-008 write_strobe  input  1  1 = write cycle, 0 = read cycle.
REQ-009 cs  input  1  chip select, decoded externally for byte window 0x30xxxx.
REQ-010 bus_ack  output  1  transfer acknowledge (DTACK equivalent).

Function
REQ-011 Request SHALL mean cs and (uds or lds).
REQ-012 bus_ack SHALL be 0 with no request; on the first rising edge with a request and bus_ack=0, bus_ack SHALL go to 1 for exactly one cycle.
REQ-013 If the request is still held after the ack cycle, bus_ack SHALL alternate 0/1 and restart a new transfer each time.
REQ-014 Writes SHALL commit on the edge that raises bus_ack, per byte lane (uds to [15:8], lds to [7:0]).
REQ-015 Reads SHALL load dout on the same edge; dout SHALL stay stable until the next read.
REQ-016 Offset 0x0000-0x3BFF (byte) SHALL be buffer RAM of 7680 x 16.
REQ-017 Register map (byte offsets, 16 bits each): 0x3C00 CMD, 0x3C02 TIME_H, 0x3C04 TIME_L, 0x3C06 FILE, 0x3C08 CHAN_H, 0x3C0A CHAN_L, 0x3C0C ACHAN, 0x3FF4 ABUF, 0x3FF6 XBUF, 0x3FF8 DMACTL, 0x3FFA ZBUF, 0x3FFC IVEC, 0x3FFE DBUF.
REQ-018 All registers SHALL be read/write, except the XBUF and DBUF bit-15 rules below.
REQ-019 A write to DBUF with din[15]=1 (uds set) SHALL start a command and set busy; DBUF[15] SHALL read 1 while busy.
REQ-020 Command completion SHALL occur exactly 16 cycles after the start edge: DBUF[15] cleared, XBUF[15] set, and XBUF[7:0] loaded with CMD[7:0].
REQ-021 A DBUF start while already busy SHALL restart the 16-cycle count.
REQ-022 A read of XBUF SHALL return the current value, then clear XBUF[15] on the same edge.
REQ-023 If completion and an XBUF read hit the same edge, the read SHALL return 0 in bit 15 and XBUF[15] SHALL end as 1.
REQ-024 Unmapped offsets SHALL read 0x0000; writes to them SHALL be ignored; both SHALL still be acknowledged.

Reset
REQ-025 Reset SHALL clear bus_ack, dout, busy, the counter and all registers to 0x0000.
REQ-026 Buffer RAM contents SHALL be unaffected by reset.
REQ-027 Reset asserted mid-transfer or mid-command SHALL abort it; no completion SHALL follow.

Configuration
REQ-028 Macro CDIC_BUFFER_RAM_EN: when defined, the buffer RAM of REQ-016 SHALL be present.
REQ-029 When CDIC_BUFFER_RAM_EN is undefined, the 0x0000-0x3BFF range SHALL read 0x0000 and ignore writes, with identical ack timing; the register map SHALL be unchanged.

Verification
REQ-030 Write 0x1234 to CMD (0x303C00) with uds=lds=1, then read it -> each ack lasts one cycle; read returns 0x1234.
REQ-031 Write 0xABCD to FILE, then write 0x0099 with lds only -> read returns 0xAB99.
REQ-032 Write CMD=0x0023, then DBUF=0x8000; poll -> DBUF[15]=1 for 16 cycles, then XBUF reads 0x8023; a second XBUF read returns 0x0023.
REQ-033 Hold a read request on 0x303C06 for 6 cycles -> bus_ack pattern 0,1,0,1,0,1.
REQ-034 Write 0x5A5A to RAM word 0x300100 and read it back -> 0x5A5A with the macro defined, 0x0000 without; read of 0x303D00 -> 0x0000.
REQ-035 Assert reset 5 cycles after a DBUF start -> XBUF stays 0x0000 and all registers read 0x0000.
